// File: rtl/pwm_dac.sv
// PWM DAC: samples a 16-bit level once per PWM period and drives a single-bit
// pulse-width-modulated output. Define PWM_DAC_DITHER_EN for error-feedback dithering.
module pwm_dac #(
  parameter int PWM_BITS = 10,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [15:0]         level,
  input  logic                invert,
  output logic                pwm_out,
  output logic                frame_start,
  output logic [PWM_BITS-1:0] duty
);

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state, state_next;
  logic [PRE_W-1:0]    pre, pre_next;
  logic [PWM_BITS-1:0] cnt, cnt_next;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] trunc;
  logic [PWM_BITS-1:0] quant;
  logic                tick;
  logic                latch;
  logic                pwm_next;
  logic                frame_next;

  assign trunc = level[15 -: PWM_BITS];
  assign tick  = (pre == PRE_LAST);

  // Quantiser: plain truncation, or truncation plus carry from the error accumulator.
`ifdef PWM_DAC_DITHER_EN
  if (PWM_BITS < 16) begin : g_dither
    localparam int LSB_W = 16 - PWM_BITS;
    logic [LSB_W-1:0] err;
    logic [LSB_W:0]   sum;

    assign sum   = {1'b0, err} + {1'b0, level[LSB_W-1:0]};
    assign quant = (sum[LSB_W] && (trunc != CNT_MAX)) ? trunc + PWM_BITS'(1) : trunc;

    // The error is only cleared by reset; it carries across idle stretches.
    always_ff @(posedge clk) begin
      if (reset) begin
        err <= '0;
      end else if (latch) begin
        err <= sum[LSB_W-1:0];
      end
    end
  end else begin : g_no_dither
    assign quant = trunc;
  end
`else
  assign quant = trunc;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_next = state;
    pre_next   = pre;
    cnt_next   = cnt;
    latch      = 1'b0;

    case (state)
      IDLE: begin
        pre_next = '0;
        cnt_next = '0;
        if (enable) begin
          state_next = RUN;
          latch      = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // The current period is abandoned outright.
          state_next = IDLE;
          pre_next   = '0;
          cnt_next   = '0;
        end else begin
          pre_next = tick ? '0 : pre + PRE_W'(1);
          if (tick) begin
            cnt_next = cnt + PWM_BITS'(1);
            latch    = (cnt == CNT_MAX);
          end
        end
      end
      default: begin
        state_next = IDLE;
        pre_next   = '0;
        cnt_next   = '0;
      end
    endcase

    duty_next  = latch ? quant : duty;
    pwm_next   = (state == RUN && enable) ? ((cnt < duty) ^ invert) : invert;
    frame_next = (state_next == RUN) && (pre_next == '0) && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= IDLE;
      pre         <= '0;
      cnt         <= '0;
      duty        <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      pre         <= pre_next;
      cnt         <= cnt_next;
      duty        <= duty_next;
      pwm_out     <= pwm_next;
      frame_start <= frame_next;
    end
  end

endmodule
